// File: rtl/mipi_csi_packet_decoder_if.sv
// Word-aligned CSI-2 byte stream into the packet decoder and the payload, line and frame
// strobes out of it.
interface mipi_csi_packet_decoder_if;
    logic        data_valid_i;
    logic [31:0] data_i;
    logic        output_valid_o;
    logic [31:0] output_o;
    logic        line_valid_o;
    logic        frame_start_o;
    logic        frame_end_o;
    logic        packet_error_o;

    modport master (
        output data_valid_i, data_i,
        input  output_valid_o, output_o, line_valid_o,
               frame_start_o, frame_end_o, packet_error_o
    );

    modport slave (
        input  data_valid_i, data_i,
        output output_valid_o, output_o, line_valid_o,
               frame_start_o, frame_end_o, packet_error_o
    );
endinterface

// File: rtl/mipi_csi_packet_decoder.sv
// CSI-2 packet header parser: forwards payload words of matching long packets and
// raises frame start/end strobes from short packets.
module mipi_csi_packet_decoder #(
    parameter logic [5:0] DATA_TYPE       = 6'h2B,
    parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    mipi_csi_packet_decoder_if.slave     csi
);
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned COUNT_W  = 16;
    localparam int unsigned BYTES_PW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [COUNT_W-1:0]   remaining, remaining_nxt;
    logic [WORD_W-1:0]    out_q, out_nxt;
    logic                 valid_q, valid_nxt;
    logic                 line_q, line_nxt;
    logic                 fs_q, fs_nxt;
    logic                 fe_q, fe_nxt;
    logic                 err_q, err_nxt;

    // Header fields are only meaningful on the first valid word in IDLE.
    logic [1:0]           hdr_vc;
    logic [5:0]           hdr_dt;
    logic [COUNT_W-1:0]   hdr_wc;
    logic                 hdr_vc_match;
    logic                 hdr_short;
    logic                 hdr_long_match;
    logic                 last_word;

    assign hdr_vc         = csi.data_i[7:6];
    assign hdr_dt         = csi.data_i[5:0];
    assign hdr_wc         = {csi.data_i[23:16], csi.data_i[15:8]};
    assign hdr_vc_match   = (hdr_vc == VIRTUAL_CHANNEL);
    assign hdr_short      = (hdr_dt < 6'h10);
    assign hdr_long_match = hdr_vc_match && (hdr_dt == DATA_TYPE);
    assign last_word      = (remaining <= COUNT_W'(BYTES_PW));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (csi.data_valid_i) begin
                    if (hdr_long_match && (hdr_wc != '0)) begin
                        state_nxt = PAYLOAD;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            PAYLOAD: begin
                if (!csi.data_valid_i) begin
                    state_nxt = IDLE;
                end else if (last_word) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!csi.data_valid_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for every registered output and the byte counter.
    always_comb begin
        valid_nxt     = 1'b0;
        line_nxt      = 1'b0;
        fs_nxt        = 1'b0;
        fe_nxt        = 1'b0;
        err_nxt       = 1'b0;
        out_nxt       = out_q;
        remaining_nxt = remaining;
        unique case (state)
            IDLE: begin
                if (csi.data_valid_i && hdr_short && hdr_vc_match) begin
                    fs_nxt = (hdr_dt == 6'h00);
                    fe_nxt = (hdr_dt == 6'h01);
                end
                if (csi.data_valid_i && hdr_long_match) begin
                    remaining_nxt = hdr_wc;
                end
            end
            PAYLOAD: begin
                if (csi.data_valid_i) begin
                    out_nxt       = csi.data_i;
                    valid_nxt     = 1'b1;
                    line_nxt      = 1'b1;
                    remaining_nxt = last_word ? '0 : remaining - COUNT_W'(BYTES_PW);
                end else begin
                    err_nxt = 1'b1;
                end
            end
            DRAIN:   ;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            remaining <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            line_q    <= 1'b0;
            fs_q      <= 1'b0;
            fe_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            remaining <= remaining_nxt;
            out_q     <= out_nxt;
            valid_q   <= valid_nxt;
            line_q    <= line_nxt;
            fs_q      <= fs_nxt;
            fe_q      <= fe_nxt;
            err_q     <= err_nxt;
        end
    end

    assign csi.output_o       = out_q;
    assign csi.output_valid_o = valid_q;
    assign csi.line_valid_o   = line_q;
    assign csi.frame_start_o  = fs_q;
    assign csi.frame_end_o    = fe_q;
    assign csi.packet_error_o = err_q;
endmodule

// File: doc/mipi_csi_packet_decoder.md
Name: mipi_csi_packet_decoder

Overview:
- Upstream neighbour of mipi_rx_raw_depacker. Consumes the word-aligned 4-lane byte stream from the lane aligner, one 32-bit word per cycle.
- Parses CSI-2 packet headers. Forwards only the payload words of long packets whose data type and virtual channel match the configuration. Generates line_valid plus frame start/end strobes for the debayer/reformatter chain.

Parameters:
- DATA_TYPE, 6'h2B: long-packet data type to forward (RAW10).
- VIRTUAL_CHANNEL, 2'd0: virtual channel to accept; packets on any other VC are ignored.

Ports:
- clk_i  in  1  byte-domain clock
- reset_i  in  1  synchronous, active-high reset
- data_valid_i  in  1  aligned word valid; high for the whole packet, low between packets
- data_i  in  32  aligned word; byte [7:0] is first in time
- output_valid_o  out  1  payload word valid (drives depacker data_valid_i)
- output_o  out  32  payload word, same byte order as data_i
- line_valid_o  out  1  high from first to last payload word of a forwarded line
- frame_start_o  out  1  one-cycle pulse on accepted Frame Start short packet
- frame_end_o  out  1  one-cycle pulse on accepted Frame End short packet
- packet_error_o  out  1  one-cycle pulse on truncated long packet

Behaviour:
- Reset (clk_i edge with reset_i=1): all outputs 0, state=IDLE, byte counter=0. Reset wins over every other event, including mid-packet; the next packet is decoded from its header.
- All outputs are registered. Latency from data_i to output_o is 1 cycle.
- Header word: DI=data_i[7:0], VC=DI[7:6], DT=DI[5:0], WC={data_i[23:16],data_i[15:8]}, ECC=data_i[31:24]. ECC is ignored.
- IDLE: on the first cycle with data_valid_i=1, decode the header.
  - DT<6'h10 (short packet), VC match:
    - DT=0x00: pulse frame_start_o.
    - DT=0x01: pulse frame_end_o.
    - Other short DT: no action.
    - Go to DRAIN.
  - DT=DATA_TYPE, VC match, WC>0: load remaining = WC, go to PAYLOAD.
  - DT=DATA_TYPE, VC match, WC=0: go to DRAIN. No line_valid.
  - Any other header: go to DRAIN.
- PAYLOAD: each cycle with data_valid_i=1:
  - output_o<=data_i, output_valid_o<=1, line_valid_o<=1.
  - remaining<=remaining-4, saturating at 0.
  - When remaining<=4, this word is the last. Next cycle: line_valid_o=0, state=DRAIN.
  - Words forwarded = ceil(WC/4). Trailing bytes of the last word (CRC/padding) are passed through unmodified; the depacker discards them.
- PAYLOAD with data_valid_i=0 before the last word:
  - Truncation. Pulse packet_error_o.
  - output_valid_o=0, line_valid_o=0 on the next cycle.
  - Go to IDLE.
- DRAIN: ignore data, hold output_valid_o=0. Return to IDLE on the first cycle data_valid_i=0. Words after the payload (CRC, trailing fill) never reach the output.
- output_valid_o=0 whenever state is not PAYLOAD. output_o holds its last value when not valid.
- Back-to-back packets need at least one data_valid_i=0 cycle between them. A header arriving while in DRAIN is ignored.
- Arithmetic: remaining is 16-bit unsigned. WC up to 16'hFFFF is supported, giving 16384 words.

Test Plan:
- Long packet: header 32'hXX0014_2B (WC=20, DT=0x2B, VC=0), then 5 payload words 12345678, 00BCDEF0, 12005678, 9ABC00F0, BBBBBB00, then 1 CRC word, valid drops.
  - output_valid_o is high for exactly 5 cycles, one cycle delayed, same data.
  - line_valid_o is high for 5 cycles; the CRC word is not forwarded.
- Short packets: DI=0x00 -> frame_start_o pulses 1 cycle. DI=0x01 -> frame_end_o pulses 1 cycle. Neither raises output_valid_o.
- Filtering:
  - DI=0x6B (VC=1) with WC=20: no output.
  - DT=0x2A with WC=20: no output.
  - Next valid 0x2B packet is forwarded normally.
- Odd WC=22: 6 words forwarded (ceil), then DRAIN. Truncation: WC=20 with data_valid_i dropping after 3 payload words -> 3 words out, packet_error_o pulses once, line_valid_o falls, next packet decodes.
- Reset: assert reset_i during the 2nd payload word -> next cycle all outputs 0. Deassert, then send a full 20-byte packet -> 5 words forwarded.
- Frame sequence: FS, 3 lines of WC=20 each separated by idle gaps, FE -> 15 output words total, 3 line_valid_o pulses of length 5, FS and FE pulses in order.
